// File: rtl/phytx_pkg.sv
// Shared constants and byte-striping helpers for the n-lane PHY transmitter.
// PHYTX_IDLE_SYM_EN selects the 0xBC idle symbol instead of an all-zero idle.
package phytx_pkg;

    localparam logic [7:0] IDLE_SYM = 8'hBC;

`ifdef PHYTX_IDLE_SYM_EN
    localparam logic [7:0] IDLE_BYTE = IDLE_SYM;
`else
    localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

    function automatic int lane_of(input int i, input int lanes);
        return i % lanes;
    endfunction

    function automatic int slot_of(input int i, input int lanes);
        return i / lanes;
    endfunction

endpackage

// File: rtl/phytx_fifo.sv
// Synchronous word FIFO with level count and async active-low reset.
// Push is ignored when full, pop is ignored when empty.
module phytx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/phytx_nlane.sv
// Single-clock n-lane PHY transmitter: FIFO, byte striping, lockstep serialisers.
// Define PHYTX_IDLE_SYM_EN to send 0xBC on idle lanes instead of zeros.
module phytx_nlane
    import phytx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk_f,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid_in,
    output logic                     in_ready,
    output logic [LANES-1:0]         data_out,
    output logic                     tx_active,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int FRAME  = WIDTH / LANES;
    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(FRAME);

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
    localparam logic [LANES-1:0][FRAME-1:0] IDLE_PAT = {NBYTES{IDLE_BYTE}};

    logic [CW-1:0]                cnt;
    logic [LANES-1:0][FRAME-1:0]  sr;
    logic [LANES-1:0][FRAME-1:0]  sr_next;
    logic [LANES-1:0][FRAME-1:0]  striped;
    logic [WIDTH-1:0]             head;
    logic                         load;
    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         pop;

    assign load     = (cnt == CNT_LAST);
    assign push     = valid_in & ~full;
    assign pop      = load & ~empty;
    assign in_ready = ~full;

    phytx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_f),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Byte i lands in lane i%LANES; slot 0 occupies the MSBs so it goes first.
    for (genvar i = 0; i < NBYTES; i++) begin : g_stripe
        localparam int LN = lane_of(i, LANES);
        localparam int SL = slot_of(i, LANES);
        assign striped[LN][FRAME-1-8*SL -: 8] = head[WIDTH-1-8*i -: 8];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sr_next[l]  = {sr[l][FRAME-2:0], 1'b0};
        assign data_out[l] = sr[l][FRAME-1];
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sr        <= IDLE_PAT;
            tx_active <= 1'b0;
        end else begin
            if (load) begin
                cnt       <= '0;
                sr        <= empty ? IDLE_PAT : striped;
                tx_active <= ~empty;
            end else begin
                cnt <= cnt + CW'(1);
                sr  <= sr_next;
            end
        end
    end

endmodule

// File: tb/tb_phytx_nlane.sv
// Directed bench for phytx_nlane: a 2-lane and a 4-lane instance share clock/reset.
// Frames are reassembled from the serial lanes and checked against hand values.
module tb_phytx_nlane;

`ifdef PHYTX_IDLE_SYM_EN
    localparam logic [7:0] IDLE_B = 8'hBC;
`else
    localparam logic [7:0] IDLE_B = 8'h00;
`endif
    localparam logic [15:0] IDLE16 = {2{IDLE_B}};

    typedef struct packed {
        logic [3:0][15:0] ln;
        logic             act;
        logic             stable;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] din_a;
    logic        vin_a;
    logic        rdy_a;
    logic [1:0]  dout_a;
    logic        txa_a;
    logic [2:0]  lvl_a;

    logic [63:0] din_b;
    logic        vin_b;
    logic        rdy_b;
    logic [3:0]  dout_b;
    logic        txa_b;
    logic [2:0]  lvl_b;

    int ncmp   = 0;
    int nfail  = 0;
    int ecount = 0;

    frame_t qa[$];
    frame_t qb[$];

    phytx_nlane #(.WIDTH(32), .LANES(2), .DEPTH(4)) dut_a (
        .clk_f      (clk),
        .reset      (rst),
        .data_in    (din_a),
        .valid_in   (vin_a),
        .in_ready   (rdy_a),
        .data_out   (dout_a),
        .tx_active  (txa_a),
        .fifo_level (lvl_a)
    );

    phytx_nlane #(.WIDTH(64), .LANES(4), .DEPTH(4)) dut_b (
        .clk_f      (clk),
        .reset      (rst),
        .data_in    (din_b),
        .valid_in   (vin_b),
        .in_ready   (rdy_b),
        .data_out   (dout_b),
        .tx_active  (txa_b),
        .fifo_level (lvl_b)
    );

    initial forever #5 clk = ~clk;

    // Edge counter mirrors the frame phase: edge k after reset has cnt=(k-1)%16.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) ecount = 0;
        else      ecount = ecount + 1;
    end

    initial begin : mon
        frame_t fa;
        frame_t fb;
        int     pos;
        fa = '0;
        fb = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ecount >= 16) begin
                pos = ecount % 16;
                for (int l = 0; l < 2; l++) fa.ln[l][15-pos] = dout_a[l];
                for (int l = 0; l < 4; l++) fb.ln[l][15-pos] = dout_b[l];
                if (pos == 0) begin
                    fa.act = txa_a;
                    fa.stable = 1'b1;
                    fb.act = txa_b;
                    fb.stable = 1'b1;
                end else begin
                    if (txa_a !== fa.act) fa.stable = 1'b0;
                    if (txa_b !== fb.act) fb.stable = 1'b0;
                end
                if (pos == 15) begin
                    qa.push_back(fa);
                    qb.push_back(fb);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        int guard;
        guard = 0;
        while (ecount < target && guard < 1000) begin
            tick();
            guard++;
        end
        chk("wait_bound", 64'(ecount >= target), 64'(1));
    endtask

    function automatic logic [3:0][15:0] stripe2(input logic [31:0] w);
        logic [3:0][15:0] r;
        r = '0;
        r[0] = {w[31:24], w[15:8]};
        r[1] = {w[23:16], w[7:0]};
        return r;
    endfunction

    function automatic logic [3:0][15:0] idle_exp(input int nl);
        logic [3:0][15:0] r;
        r = '0;
        for (int l = 0; l < nl; l++) r[l] = IDLE16;
        return r;
    endfunction

    task automatic chk_frame(input string tag, input frame_t f,
                             input logic [3:0][15:0] exp, input int nl,
                             input logic act);
        for (int l = 0; l < nl; l++)
            chk($sformatf("%s_lane%0d", tag, l), 64'(f.ln[l]), 64'(exp[l]));
        chk({tag, "_act"}, 64'(f.act), 64'(act));
        chk({tag, "_act_stable"}, 64'(f.stable), 64'(1));
    endtask

    logic [31:0]      burst [6];
    logic [3:0][15:0] bexp;
    int               sent;
    int               guard;
    int               max_lvl;
    logic             acc;
    logic             saw_full;
    logic             rdy_ok;

    initial begin
        burst[0] = 32'h11223344;
        burst[1] = 32'h55667788;
        burst[2] = 32'h99AABBCC;
        burst[3] = 32'hDDEEFF00;
        burst[4] = 32'h0F1E2D3C;
        burst[5] = 32'hA5A55A5A;
        bexp = '0;
        bexp[0] = 16'h0105;
        bexp[1] = 16'h0206;
        bexp[2] = 16'h0307;
        bexp[3] = 16'h0408;

        rst = 1'b1;
        vin_a = 1'b0;
        vin_b = 1'b0;
        din_a = '0;
        din_b = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_in_ready", 64'(rdy_a), 64'(1));
        chk("rst_level", 64'(lvl_a), 64'(0));
        chk("rst_tx_active", 64'(txa_a), 64'(0));
        chk("rst_dout_a", 64'(dout_a), 64'({2{IDLE_B[7]}}));
        chk("rst_dout_b", 64'(dout_b), 64'({4{IDLE_B[7]}}));
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset
        wait_to(32);
        chk_frame("idle_a", qa[0], idle_exp(2), 2, 1'b0);
        chk_frame("idle_b", qb[0], idle_exp(4), 4, 1'b0);
        chk("idle_in_ready", 64'(rdy_a), 64'(1));
        chk("idle_level", 64'(lvl_a), 64'(0));
        qa.delete();
        qb.delete();

        // Single word pushed mid-frame
        wait_to(37);
        din_a = 32'hAABBCCDD;
        din_b = 64'h0102030405060708;
        vin_a = 1'b1;
        vin_b = 1'b1;
        tick();
        vin_a = 1'b0;
        vin_b = 1'b0;
        chk("single_level_a", 64'(lvl_a), 64'(1));
        chk("single_level_b", 64'(lvl_b), 64'(1));
        chk("single_tx_pre", 64'(txa_a), 64'(0));
        wait_to(80);
        chk_frame("single_pre_a", qa[0], idle_exp(2), 2, 1'b0);
        chk_frame("single_a", qa[1], stripe2(32'hAABBCCDD), 2, 1'b1);
        chk_frame("single_post_a", qa[2], idle_exp(2), 2, 1'b0);
        chk_frame("single_b", qb[1], bexp, 4, 1'b1);
        chk_frame("single_post_b", qb[2], idle_exp(4), 4, 1'b0);
        chk("single_level_end", 64'(lvl_a), 64'(0));
        qa.delete();
        qb.delete();

        // Burst of 6 with valid held high
        sent = 0;
        guard = 0;
        max_lvl = 0;
        saw_full = 1'b0;
        rdy_ok = 1'b1;
        while (sent < 6 && guard < 200) begin
            vin_a = 1'b1;
            din_a = burst[sent];
            acc = rdy_a;
            tick();
            guard++;
            if (acc) sent++;
            if (rdy_a !== (lvl_a != 3'd4)) rdy_ok = 1'b0;
            if (!rdy_a) saw_full = 1'b1;
            if (int'(lvl_a) > max_lvl) max_lvl = int'(lvl_a);
        end
        vin_a = 1'b0;
        chk("burst_sent", 64'(sent), 64'(6));
        chk("burst_saw_full", 64'(saw_full), 64'(1));
        chk("burst_ready_vs_level", 64'(rdy_ok), 64'(1));
        chk("burst_max_level", 64'(max_lvl), 64'(4));
        wait_to(208);
        chk_frame("burst_pre", qa[0], idle_exp(2), 2, 1'b0);
        for (int k = 0; k < 6; k++)
            chk_frame($sformatf("burst_w%0d", k), qa[k+1], stripe2(burst[k]),
                      2, 1'b1);
        chk_frame("burst_post", qa[7], idle_exp(2), 2, 1'b0);
        chk("burst_level_end", 64'(lvl_a), 64'(0));
        qa.delete();
        qb.delete();

        // Push and pop on the same load edge at level 2
        vin_a = 1'b1;
        din_a = 32'hC0DE0001;
        tick();
        din_a = 32'hC0DE0002;
        tick();
        vin_a = 1'b0;
        chk("same_level_pre", 64'(lvl_a), 64'(2));
        wait_to(223);
        chk("same_ready", 64'(rdy_a), 64'(1));
        vin_a = 1'b1;
        din_a = 32'hC0DE0003;
        tick();
        vin_a = 1'b0;
        chk("same_level_post", 64'(lvl_a), 64'(2));
        wait_to(288);
        chk_frame("same_x", qa[1], stripe2(32'hC0DE0001), 2, 1'b1);
        chk_frame("same_y", qa[2], stripe2(32'hC0DE0002), 2, 1'b1);
        chk_frame("same_z", qa[3], stripe2(32'hC0DE0003), 2, 1'b1);
        chk_frame("same_post", qa[4], idle_exp(2), 2, 1'b0);

        // Asynchronous reset mid-frame with words queued
        vin_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din_a = 32'h5A5A0000 | 32'(k);
            tick();
        end
        vin_a = 1'b0;
        wait_to(308);
        chk("mid_level_pre", 64'(lvl_a), 64'(3));
        chk("mid_tx_pre", 64'(txa_a), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_level", 64'(lvl_a), 64'(0));
        chk("mid_rst_tx", 64'(txa_a), 64'(0));
        chk("mid_rst_ready", 64'(rdy_a), 64'(1));
        chk("mid_rst_dout_a", 64'(dout_a), 64'({2{IDLE_B[7]}}));
        chk("mid_rst_dout_b", 64'(dout_b), 64'({4{IDLE_B[7]}}));
        @(negedge clk);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        wait_to(48);
        chk_frame("after_rst0", qa[0], idle_exp(2), 2, 1'b0);
        chk_frame("after_rst1", qa[1], idle_exp(2), 2, 1'b0);
        chk("after_rst_level", 64'(lvl_a), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
